// File: rtl/f_redirect_ctrl.sv
// Front-end redirect scheduler: arbitrates redirect sources, flushes fetch, drains, then offers the target PC.
// Optional per-source capture counters are built when F_REDIR_PERF_EN is defined.
module f_redirect_ctrl #(
    parameter logic [31:0] INIT_PC     = 32'h1c00_0000,
    parameter int unsigned FLUSH_DRAIN = 2,
    parameter int unsigned EPOCH_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exc_redir_valid_i,
    input  logic [31:0]          exc_redir_pc_i,
    input  logic [1:0]           bk_redir_valid_i,
    input  logic [1:0][31:0]     bk_redir_pc_i,
    input  logic                 dec_redir_valid_i,
    input  logic [31:0]          dec_redir_pc_i,
    output logic                 redir_valid_o,
    output logic [31:0]          redir_pc_o,
    input  logic                 redir_ready_i,
    output logic                 g_flush_o,
    output logic                 fetch_stall_o,
    output logic [EPOCH_W-1:0]   epoch_o,
    output logic [3:0][31:0]     perf_cnt_o
);
    typedef enum logic [1:0] {S_BOOT, S_IDLE, S_DRAIN, S_ISSUE} state_t;

    localparam logic [1:0] LVL_DEC = 2'd0;
    localparam logic [1:0] LVL_BK1 = 2'd1;
    localparam logic [1:0] LVL_BK0 = 2'd2;
    localparam logic [1:0] LVL_EXC = 2'd3;
    localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_DRAIN - 1);

    state_t               state_q;
    logic                 redir_valid_q;
    logic                 flush_q;
    logic                 stall_q;
    logic [31:0]          pc_q;
    logic [EPOCH_W-1:0]   epoch_q;
    logic                 pend_q;
    logic [1:0]           lvl_q;
    logic [3:0]           cnt_q;

    logic                 win_vld_d;
    logic [1:0]           win_lvl_d;
    logic [31:0]          win_pc_d;
    logic                 take_d;

    always_comb begin
        win_vld_d = 1'b1;
        win_lvl_d = LVL_DEC;
        win_pc_d  = dec_redir_pc_i;
        if (exc_redir_valid_i) begin
            win_lvl_d = LVL_EXC;
            win_pc_d  = exc_redir_pc_i;
        end else if (bk_redir_valid_i[0]) begin
            win_lvl_d = LVL_BK0;
            win_pc_d  = bk_redir_pc_i[0];
        end else if (bk_redir_valid_i[1]) begin
            win_lvl_d = LVL_BK1;
            win_pc_d  = bk_redir_pc_i[1];
        end else if (!dec_redir_valid_i) begin
            win_vld_d = 1'b0;
        end
        win_pc_d = win_pc_d & 32'hFFFF_FFFC;
    end

    // Outside IDLE a predecode redirect is stale; only equal-or-higher sources may preempt.
    always_comb begin
        take_d = 1'b0;
        case (state_q)
            S_IDLE:  take_d = win_vld_d;
            S_BOOT:  take_d = win_vld_d && (win_lvl_d == LVL_EXC);
            default: take_d = win_vld_d && (win_lvl_d != LVL_DEC) &&
                              (!pend_q || (win_lvl_d >= lvl_q));
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_BOOT;
            redir_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b1;
            pc_q          <= INIT_PC;
            epoch_q       <= '0;
            pend_q        <= 1'b0;
            lvl_q         <= LVL_DEC;
            cnt_q         <= '0;
        end else begin
            flush_q <= 1'b0;
            if (take_d) begin
                // An in-flight ISSUE handshake still completes; the new target restarts the drain.
                state_q       <= S_DRAIN;
                redir_valid_q <= 1'b0;
                flush_q       <= 1'b1;
                stall_q       <= 1'b1;
                pc_q          <= win_pc_d;
                lvl_q         <= win_lvl_d;
                pend_q        <= 1'b1;
                epoch_q       <= epoch_q + EPOCH_W'(1);
                cnt_q         <= DRAIN_INIT;
            end else begin
                case (state_q)
                    S_BOOT: begin
                        state_q       <= S_ISSUE;
                        redir_valid_q <= 1'b1;
                        pc_q          <= INIT_PC;
                        lvl_q         <= LVL_EXC;
                        pend_q        <= 1'b1;
                    end
                    S_DRAIN: begin
                        if (cnt_q == 4'd0) begin
                            state_q       <= S_ISSUE;
                            redir_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    S_ISSUE: begin
                        if (redir_ready_i) begin
                            state_q       <= S_IDLE;
                            redir_valid_q <= 1'b0;
                            stall_q       <= 1'b0;
                            pend_q        <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign redir_valid_o = redir_valid_q;
    assign redir_pc_o    = pc_q;
    assign g_flush_o     = flush_q;
    assign fetch_stall_o = stall_q;
    assign epoch_o       = epoch_q;

`ifdef F_REDIR_PERF_EN
    // Indexed by level: [3]=EXC, [2]=BK0, [1]=BK1, [0]=DEC.
    logic [3:0][31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (take_d && (perf_q[win_lvl_d] != 32'hFFFF_FFFF)) begin
            perf_q[win_lvl_d] <= perf_q[win_lvl_d] + 32'd1;
        end
    end

    assign perf_cnt_o = perf_q;
`else
    assign perf_cnt_o = '0;
`endif
endmodule
